// File: rtl/nibble_serial_alu_ctrl_if.sv
// -----------------------------------------------------------------------------
// nibble_serial_alu_ctrl_if
// Request/response bundle between the datapath and nibble_serial_alu_ctrl.
//
// Handshake (valid/ready semantics):
//   start is a request that the controller samples only while idle. There is
//   no separate ready signal. A request is accepted on the rising edge where
//   start=1 and the controller is idle. a/b/ALUop are captured on that same
//   edge. busy is high while the operation runs. done is a one-cycle pulse,
//   and result/c_out are valid in that cycle. start seen while busy or in the
//   done cycle is dropped, not queued.
//
// Signals (master = datapath, slave = controller):
//   start       m->s  1      operation request
//   a, b        m->s  WIDTH  operands (b un-inverted)
//   ALUop       m->s  3      operation code (bit 2 = subtract)
//   busy        s->m  1      operation in progress
//   done        s->m  1      completion pulse
//   result      s->m  WIDTH  assembled result, held until the next start
//   c_out       s->m  1      carry out of the MSB nibble
//   zero        s->m  1      result == 0        (NIBBLE_ALU_FLAGS_EN only)
//   overflow    s->m  1      signed overflow    (NIBBLE_ALU_FLAGS_EN only)
//
// Optional feature macro: NIBBLE_ALU_FLAGS_EN
// -----------------------------------------------------------------------------
interface nibble_serial_alu_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int WIDTH = 4 * NIBBLES;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       ALUop;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
`ifdef NIBBLE_ALU_FLAGS_EN
  logic             zero;
  logic             overflow;

  modport master (
    output start, a, b, ALUop,
    input  busy, done, result, c_out, zero, overflow
  );

  modport slave (
    input  start, a, b, ALUop,
    output busy, done, result, c_out, zero, overflow
  );
`else
  modport master (
    output start, a, b, ALUop,
    input  busy, done, result, c_out
  );

  modport slave (
    input  start, a, b, ALUop,
    output busy, done, result, c_out
  );
`endif
endinterface

// File: rtl/nibble_serial_alu_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_alu_ctrl
// Runs one WIDTH-bit ALU operation through a shared external 4-bit
// carry-lookahead slice. It processes one nibble per cycle, LSB nibble first.
// The inter-nibble carry ripples through r_carry using the group terms of the
// slice: carry_next = g | (p & carry).
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   bus            nibble_serial_alu_ctrl_if.slave (start/a/b/ALUop in,
//                  busy/done/result/c_out [+ zero/overflow] out)
//   slice_a/_b     current operand nibbles to the slice (b raw, the slice
//                  inverts for subtract)
//   slice_c_in     carry into the slice
//   slice_ALUop    captured operation code to the slice
//   slice_result   slice result nibble (combinational from slice_* outputs)
//   slice_p/_g     slice group propagate / generate
//   o_dbg_state    FSM state, 0=IDLE 1=RUN 2=DONE
//
// Optional feature macro: NIBBLE_ALU_FLAGS_EN adds the registered zero and
// overflow flags on the bus. These are updated with the final nibble.
//
// Timing: start accepted at edge T. busy is high for the NIBBLES cycles after
// T. done is high in cycle T+NIBBLES+1. Throughput is one op per NIBBLES+2
// cycles.
// -----------------------------------------------------------------------------
module nibble_serial_alu_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  nibble_serial_alu_ctrl_if.slave bus,
  output logic [3:0]              slice_a,
  output logic [3:0]              slice_b,
  output logic                    slice_c_in,
  output logic [2:0]              slice_ALUop,
  input  logic [3:0]              slice_result,
  input  logic                    slice_p,
  input  logic                    slice_g,
  output logic [1:0]              o_dbg_state
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int CW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_op;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic             r_c_out;

  logic             w_carry_next;
  logic [3:0]       w_nib_a;
  logic [3:0]       w_nib_b;

  assign w_carry_next = slice_g | (slice_p & r_carry);
  assign w_nib_a      = r_a[{r_cnt, 2'b00} +: 4];
  assign w_nib_b      = r_b[{r_cnt, 2'b00} +: 4];

  // r_busy is exactly "state == RUN". Gating with it holds the slice inputs
  // at 0 outside RUN, so the shared slice does not toggle while idle.
  assign slice_a     = r_busy ? w_nib_a : 4'd0;
  assign slice_b     = r_busy ? w_nib_b : 4'd0;
  assign slice_c_in  = r_busy ? r_carry : 1'b0;
  assign slice_ALUop = r_busy ? r_op    : 3'd0;

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.result  = r_result;
  assign bus.c_out   = r_c_out;
  assign o_dbg_state = r_state;

`ifdef NIBBLE_ALU_FLAGS_EN
  logic r_zero;
  logic r_overflow;
  logic w_is_arith;

  assign w_is_arith   = (r_op == 3'b010) || (r_op == 3'b110);
  assign bus.zero     = r_zero;
  assign bus.overflow = r_overflow;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_op       <= '0;
      r_carry    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_c_out    <= 1'b0;
`ifdef NIBBLE_ALU_FLAGS_EN
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_op     <= bus.ALUop;
            r_cnt    <= '0;
            // The subtract "+1" enters as the carry into nibble 0.
            r_carry  <= bus.ALUop[2];
            r_result <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end

        S_RUN: begin
          r_result[{r_cnt, 2'b00} +: 4] <= slice_result;
          r_carry                       <= w_carry_next;
          if (r_cnt == LAST) begin
            r_c_out <= w_carry_next;
`ifdef NIBBLE_ALU_FLAGS_EN
            // The upper nibble of r_result is still 0 from the start-time
            // clear. So "whole result is zero" reduces to this check.
            r_zero     <= (r_result == '0) && (slice_result == 4'd0);
            r_overflow <= w_is_arith
                          && (r_a[WIDTH-1] == (r_b[WIDTH-1] ^ r_op[2]))
                          && (slice_result[3] != r_a[WIDTH-1]);
`endif
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DONE: begin
          // start is ignored here, so back-to-back ops take NIBBLES+2 cycles.
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
